// File: rtl/traffic_light.sv
// Fixed-time six-phase T-junction lamp sequencer (M1, M2, turn lane MT, side road S).
// Moore outputs decoded directly from the phase register; no input handshake, runs freely.
module traffic_light #(
    parameter int T_MG = 7,
    parameter int T_Y  = 2,
    parameter int T_TG = 5,
    parameter int T_SG = 3,
    parameter int CW   = 4
) (
    input  logic       clk,
    input  logic       r,
    output logic [2:0] m1,
    output logic [2:0] m2,
    output logic [2:0] mt,
    output logic [2:0] s
);

    typedef enum logic [2:0] {
        S1 = 3'd0,
        S2 = 3'd1,
        S3 = 3'd2,
        S4 = 3'd3,
        S5 = 3'd4,
        S6 = 3'd5
    } state_e;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Plain vector register so codes 6/7 remain representable and recoverable.
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] last;
    logic [2:0]    next_phase;
    logic          legal;

    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= S1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        last       = '0;
        next_phase = S1;
        legal      = 1'b1;
        case (state_q)
            S1: begin last = CW'(T_MG - 1); next_phase = S2; end
            S2: begin last = CW'(T_Y - 1);  next_phase = S3; end
            S3: begin last = CW'(T_TG - 1); next_phase = S4; end
            S4: begin last = CW'(T_Y - 1);  next_phase = S5; end
            S5: begin last = CW'(T_SG - 1); next_phase = S6; end
            S6: begin last = CW'(T_Y - 1);  next_phase = S1; end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        if (!legal) begin
            state_d = S1;
            cnt_d   = '0;
        end else if (cnt_q == last) begin
            state_d = next_phase;
            cnt_d   = '0;
        end
    end

    always_comb begin
        m1 = RED;
        m2 = RED;
        mt = RED;
        s  = RED;
        case (state_q)
            S1: begin m1 = GRN; m2 = GRN; end
            S2: begin m1 = GRN; m2 = YEL; end
            S3: begin m1 = GRN; mt = GRN; end
            S4: begin m1 = YEL; mt = YEL; end
            S5: s = GRN;
            S6: s = YEL;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light.sv
// Randomized-timing bench for traffic_light: default and all-ones timing instances,
// checked against a table-driven phase model derived from elapsed edges since reset.
module tb_traffic_light;

    logic       clk = 1'b0;
    logic       r   = 1'b0;
    logic [2:0] m1, m2, mt, s;
    logic [2:0] fm1, fm2, fmt, fs;

    int compared   = 0;
    int mismatched = 0;
    int n_main = 0;
    int n_fast = 0;
    logic [11:0] hist[$];

    traffic_light dut (
        .clk(clk), .r(r), .m1(m1), .m2(m2), .mt(mt), .s(s)
    );

    traffic_light #(.T_MG(1), .T_Y(1), .T_TG(1), .T_SG(1), .CW(1)) fast (
        .clk(clk), .r(r), .m1(fm1), .m2(fm2), .mt(fmt), .s(fs)
    );

    always #5 clk = ~clk;

    // Phase index 0..5 reached after n edges, from the per-phase durations.
    function automatic int phase_of(int n, int tmg, int ty, int ttg, int tsg);
        int d[6];
        int pos;
        int ph;
        d[0] = tmg; d[1] = ty; d[2] = ttg; d[3] = ty; d[4] = tsg; d[5] = ty;
        pos = n % (tmg + ttg + tsg + 3 * ty);
        ph  = 0;
        while (pos >= d[ph]) begin
            pos -= d[ph];
            ph++;
        end
        return ph;
    endfunction

    // {m1,m2,mt,s}: G=001 Y=010 R=100
    function automatic logic [11:0] lamps_of(int ph);
        case (ph)
            0:       return {3'b001, 3'b001, 3'b100, 3'b100};
            1:       return {3'b001, 3'b010, 3'b100, 3'b100};
            2:       return {3'b001, 3'b100, 3'b001, 3'b100};
            3:       return {3'b010, 3'b100, 3'b010, 3'b100};
            4:       return {3'b100, 3'b100, 3'b100, 3'b001};
            5:       return {3'b100, 3'b100, 3'b100, 3'b010};
            default: return {4{3'b100}};
        endcase
    endfunction

    task automatic check(string tag, logic [11:0] obs, logic [11:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_bit(string tag, logic obs);
        compared++;
        assert (obs === 1'b1)
        else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=1", tag, obs);
        end
    endtask

    task automatic check_models(string tag);
        logic [11:0] cur;
        cur = {m1, m2, mt, s};
        check({tag, "_main"}, cur, lamps_of(phase_of(n_main, 7, 2, 5, 3)));
        check({tag, "_fast"}, {fm1, fm2, fmt, fs}, lamps_of(phase_of(n_fast, 1, 1, 1, 1)));
        check_bit({tag, "_onehot"}, $onehot(m1) && $onehot(m2) && $onehot(mt) && $onehot(s));
        check_bit({tag, "_side_excl"}, (s == 3'b100) || (m1 == 3'b100 && m2 == 3'b100 && mt == 3'b100));
        check_bit({tag, "_turn_excl"}, (mt != 3'b001) || (m2 == 3'b100));
        hist.push_back(cur);
        if (hist.size() > 21)
            check({tag, "_period"}, cur, hist[hist.size() - 22]);
    endtask

    task automatic step(string tag);
        @(posedge clk);
        n_main++;
        n_fast++;
        @(negedge clk);
        check_models(tag);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_main"}, {m1, m2, mt, s}, {3'b001, 3'b001, 3'b100, 3'b100});
        check({tag, "_fast"}, {fm1, fm2, fmt, fs}, {3'b001, 3'b001, 3'b100, 3'b100});
    endtask

    // Asynchronous assert at d ns after an edge, hold for `hold` edges, release on a falling edge.
    task automatic do_reset(int d, int hold);
        @(posedge clk);
        #d;
        r = 1'b0;
        #1;
        check_reset("async_rst");
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_reset("rst_hold");
        end
        r = 1'b1;
        n_main = 0;
        n_fast = 0;
        hist.delete();
    endtask

    initial begin
        int guard;
        #1;
        check_reset("por");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_reset("rst_hold_init");
        end
        r = 1'b1;

        for (int i = 0; i < 100; i++) step("run");
        check({"wrap_s1"}, {m1, m2, mt, s}, (n_main % 21 < 7) ? lamps_of(0) : lamps_of(phase_of(n_main, 7, 2, 5, 3)));

        for (int k = 0; k < 4; k++) begin
            do_reset($urandom_range(1, 4), $urandom_range(1, 3));
            for (int i = 0; i < int'($urandom_range(3, 50)); i++) step("rnd");
        end

        guard = 0;
        while (phase_of(n_main, 7, 2, 5, 3) != 4 && guard < 30) begin
            step("to_s5");
            guard++;
        end
        check_bit("reach_s5", s == 3'b001);
        do_reset($urandom_range(1, 4), 1);
        for (int i = 0; i < 7; i++) begin
            step("post_rst_s1");
            if (i < 6) check("s1_len", {m1, m2, mt, s}, lamps_of(0));
        end
        check("s1_exit", {m1, m2, mt, s}, lamps_of(1));

        for (int i = 0; i < int'($urandom_range(2, 9)); i++) step("pre_illegal");
        force dut.state_q = 3'b111;
        #1;
        check("illegal_decode", {m1, m2, mt, s}, {4{3'b100}});
        release dut.state_q;
        @(posedge clk);
        n_main = 0;
        n_fast++;
        hist.delete();
        @(negedge clk);
        check_models("illegal_recover");
        for (int i = 0; i < 30; i++) step("post_illegal");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
